// File: rtl/load_store_unit_pkg.sv
// Shared codes and helpers for the load/store unit and its lane extractor.
package load_store_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRd   = 3'd1,
        StCap  = 3'd2,
        StWr   = 3'd3,
        StDone = 3'd4,
        StErr  = 3'd5
    } lsuState_e;

    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return offset != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    // Replace only the addressed byte/half of a word read back from memory.
    function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [15:0] data,
                                              input logic [1:0] size, input logic [1:0] offset);
        logic [31:0] merged;
        merged = word;
        if (size == SIZE_BYTE) begin
            merged[{offset, 3'b000} +: 8] = data[7:0];
        end else if (size == SIZE_HALF) begin
            merged[{offset[1], 4'b0000} +: 16] = data;
        end
        return merged;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response and RAM-side strobes of the load/store unit.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              ready;
    logic              we;
    logic [1:0]        size;
    logic              ExtSrc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Controller plus data RAM.
    modport master (
        output req, we, size, ExtSrc, addr, wdata, mem_rdata,
        input  ready, rdata, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    // The load/store unit itself.
    modport slave (
        input  req, we, size, ExtSrc, addr, wdata, mem_rdata,
        output ready, rdata, done, err, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit_lane_extract.sv
// Combinational byte/half lane select with sign or zero extension to 32 bits.
module lane_extract
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        extSrc_i,
    output logic [31:0] result_o
);
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic        signFill;

    always_comb begin
        selByte  = word_i[{offset_i, 3'b000} +: 8];
        selHalf  = word_i[{offset_i[1], 4'b0000} +: 16];
        signFill = 1'b0;
        result_o = word_i;
        case (size_i)
            SIZE_BYTE: begin
                signFill = (extSrc_i == EXT_SIGN) & selByte[7];
                result_o = {{24{signFill}}, selByte};
            end
            SIZE_HALF: begin
                signFill = (extSrc_i == EXT_SIGN) & selHalf[15];
                result_o = {{16{signFill}}, selHalf};
            end
            default: result_o = word_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sub-word stores via read-modify-write on a word-only RAM,
// sub-word loads extracted and extended to 32 bits.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input logic               CLK,
    input logic               Reset,
    load_store_unit_if.slave  bus
);
    lsuState_e stateQ, stateD;

    logic              weQ;
    logic [1:0]        sizeQ;
    logic              extSrcQ;
    logic [ADDR_W-1:0] addrQ;
    logic [15:0]       storeLowQ;
    logic [31:0]       rdataQ;
    logic [31:0]       memWdataQ;
    logic [31:0]       extracted;
    logic              startReq;
    logic              startErr;

    assign startReq = (stateQ == StIdle) && bus.req;
    assign startErr = isMisaligned(bus.size, bus.addr[1:0]);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.req) begin
                    if (startErr) begin
                        stateD = StErr;
                    end else if (bus.we && bus.size == SIZE_WORD) begin
                        stateD = StWr;
                    end else begin
                        stateD = StRd;
                    end
                end
            end
            StRd:           stateD = StCap;
            StCap:          stateD = weQ ? StWr : StDone;
            StWr:           stateD = StDone;
            StDone, StErr:  stateD = StIdle;
            default:        stateD = StIdle;
        endcase
    end

    lane_extract uLaneExtract (
        .word_i   (bus.mem_rdata),
        .size_i   (sizeQ),
        .offset_i (addrQ[1:0]),
        .extSrc_i (extSrcQ),
        .result_o (extracted)
    );

    // Word stores never read, so only the low half of wdata feeds the merge.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            weQ       <= 1'b0;
            sizeQ     <= SIZE_BYTE;
            extSrcQ   <= EXT_ZERO;
            addrQ     <= '0;
            storeLowQ <= '0;
            rdataQ    <= '0;
            memWdataQ <= '0;
        end else begin
            if (startReq) begin
                weQ       <= bus.we;
                sizeQ     <= bus.size;
                extSrcQ   <= bus.ExtSrc;
                addrQ     <= bus.addr;
                storeLowQ <= bus.wdata[15:0];
                if (!startErr && bus.we && bus.size == SIZE_WORD) begin
                    memWdataQ <= bus.wdata;
                end
            end
            if (stateQ == StCap) begin
                if (weQ) begin
                    memWdataQ <= mergeLane(bus.mem_rdata, storeLowQ, sizeQ, addrQ[1:0]);
                end else begin
                    rdataQ <= extracted;
                end
            end
        end
    end

    assign bus.ready     = (stateQ == StIdle);
    assign bus.done      = (stateQ == StDone) || (stateQ == StErr);
    assign bus.err       = (stateQ == StErr);
    assign bus.mem_rd    = (stateQ == StRd);
    assign bus.mem_wr    = (stateQ == StWr);
    assign bus.mem_addr  = {addrQ[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = memWdataQ;
    assign bus.rdata     = rdataQ;
endmodule
